// File: rtl/hero_ctl.sv
// Hero movement initiator: on each frame tick, proposes a one-STEP move, asks the
// wall checker over a req/ack handshake, and commits the move only when it is clear.
module hero_ctl #(
  parameter int X_START     = 62,
  parameter int Y_START     = 108,
  parameter int X_MIN       = 62,
  parameter int X_MAX       = 902,
  parameter int Y_MIN       = 108,
  parameter int Y_MAX       = 648,
  parameter int STEP        = 4,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        check_req,
  output logic [11:0] cand_x_pos,
  output logic [11:0] cand_y_pos,
  input  logic        check_ack,
  input  logic        check_blocked,
  output logic [11:0] hero_x_pos,
  output logic [11:0] hero_y_pos,
  output logic [1:0]  hero_dir,
  output logic        moving,
  output logic        bump
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_COMMIT   = 2'd2
  } state_e;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int          CW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [12:0] STEP13  = 13'(STEP);

  state_e        state_q;
  logic [CW-1:0] wait_cnt_q;
  logic [11:0]   hero_x_q, hero_y_q, cand_x_q, cand_y_q;
  logic [1:0]    dir_q;
  logic          req_q, moving_q, bump_q;

  logic          btn_any;
  logic [1:0]    dir_d;
  logic [12:0]   sum_x, sum_y;
  logic [11:0]   cand_x_d, cand_y_d;

  // Underflow wraps the 13-bit sum into its top bit, which also clamps to the minimum.
  function automatic logic [11:0] clamp13(input logic [12:0] v, input int lo, input int hi);
    if (v[12] || v < 13'(lo))
      return 12'(lo);
    else if (v > 13'(hi))
      return 12'(hi);
    else
      return v[11:0];
  endfunction

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    btn_any = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)        dir_d = DIR_UP;
    else if (btn_down) dir_d = DIR_DOWN;
    else if (btn_left) dir_d = DIR_LEFT;
    else               dir_d = DIR_RIGHT;

    sum_x = {1'b0, hero_x_q};
    sum_y = {1'b0, hero_y_q};
    unique case (dir_d)
      DIR_UP:   sum_y = {1'b0, hero_y_q} - STEP13;
      DIR_DOWN: sum_y = {1'b0, hero_y_q} + STEP13;
      DIR_LEFT: sum_x = {1'b0, hero_x_q} - STEP13;
      default:  sum_x = {1'b0, hero_x_q} + STEP13;
    endcase

    cand_x_d = clamp13(sum_x, X_MIN, X_MAX);
    cand_y_d = clamp13(sum_y, Y_MIN, Y_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      hero_x_q   <= 12'(X_START);
      hero_y_q   <= 12'(Y_START);
      cand_x_q   <= 12'(X_START);
      cand_y_q   <= 12'(Y_START);
      dir_q      <= DIR_DOWN;
      req_q      <= 1'b0;
      moving_q   <= 1'b0;
      bump_q     <= 1'b0;
    end else begin
      bump_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (frame_tick) begin
            moving_q <= 1'b0;
            if (btn_any) begin
              dir_q <= dir_d;
              if (cand_x_d == hero_x_q && cand_y_d == hero_y_q) begin
                bump_q <= 1'b1;
              end else begin
                cand_x_q   <= cand_x_d;
                cand_y_q   <= cand_y_d;
                req_q      <= 1'b1;
                wait_cnt_q <= '0;
                state_q    <= S_WAIT_ACK;
              end
            end
          end
        end
        S_WAIT_ACK: begin
          if (check_ack) begin
            req_q <= 1'b0;
            if (check_blocked) begin
              bump_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_COMMIT;
            end
          end else if (wait_cnt_q == TO_LAST) begin
            req_q   <= 1'b0;
            bump_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_COMMIT: begin
          hero_x_q <= cand_x_q;
          hero_y_q <= cand_y_q;
          moving_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign check_req  = req_q;
  assign cand_x_pos = cand_x_q;
  assign cand_y_pos = cand_y_q;
  assign hero_x_pos = hero_x_q;
  assign hero_y_pos = hero_y_q;
  assign hero_dir   = dir_q;
  assign moving     = moving_q;
  assign bump       = bump_q;

endmodule

// File: tb/tb_hero_ctl.sv
// Directed bench for hero_ctl: a behavioural model checked every cycle, plus
// literal expectations at the key points of each scenario.
module tb_hero_ctl;

  localparam int X_START = 62, Y_START = 108;
  localparam int X_MIN = 62, X_MAX = 902, Y_MIN = 108, Y_MAX = 648;
  localparam int STEP = 4, ACK_TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        check_ack = 1'b0, check_blocked = 1'b0;
  logic        check_req;
  logic [11:0] cand_x_pos, cand_y_pos, hero_x_pos, hero_y_pos;
  logic [1:0]  hero_dir;
  logic        moving, bump;

  int tests = 0;
  int fails = 0;

  hero_ctl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .check_req(check_req), .cand_x_pos(cand_x_pos), .cand_y_pos(cand_y_pos),
    .check_ack(check_ack), .check_blocked(check_blocked),
    .hero_x_pos(hero_x_pos), .hero_y_pos(hero_y_pos), .hero_dir(hero_dir),
    .moving(moving), .bump(bump)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending request, a pending commit and a wait counter.
  int mx = X_START, my = Y_START, mcx = X_START, mcy = Y_START;
  int mdir = 1, mwait = 0;
  bit mreq = 0, mbump = 0, mmov = 0, mcommit = 0;

  always @(posedge clk) begin
    int dx, dy, nx, ny;
    if (rst) begin
      mx = X_START; my = Y_START; mcx = X_START; mcy = Y_START;
      mdir = 1; mreq = 0; mbump = 0; mmov = 0; mcommit = 0; mwait = 0;
    end else begin
      mbump = 0;
      if (mcommit) begin
        mx = mcx; my = mcy; mmov = 1; mcommit = 0;
      end else if (mreq) begin
        if (check_ack) begin
          mreq = 0;
          if (check_blocked) mbump = 1; else mcommit = 1;
        end else begin
          mwait++;
          if (mwait == ACK_TIMEOUT) begin mreq = 0; mbump = 1; end
        end
      end else if (frame_tick) begin
        mmov = 0;
        if (btn_up | btn_down | btn_left | btn_right) begin
          dx = 0; dy = 0;
          if (btn_up)        begin dy = -1; mdir = 0; end
          else if (btn_down) begin dy = 1;  mdir = 1; end
          else if (btn_left) begin dx = -1; mdir = 2; end
          else               begin dx = 1;  mdir = 3; end
          nx = mx + dx * STEP;
          ny = my + dy * STEP;
          if (nx < X_MIN) nx = X_MIN;
          if (nx > X_MAX) nx = X_MAX;
          if (ny < Y_MIN) ny = Y_MIN;
          if (ny > Y_MAX) ny = Y_MAX;
          if (nx == mx && ny == my) mbump = 1;
          else begin mcx = nx; mcy = ny; mreq = 1; mwait = 0; end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("req", int'(check_req), int'(mreq));
      check("bump", int'(bump), int'(mbump));
      check("moving", int'(moving), int'(mmov));
      check("dir", int'(hero_dir), mdir);
      check("hero_x", int'(hero_x_pos), mx);
      check("hero_y", int'(hero_y_pos), my);
      if (mreq) begin
        check("cand_x", int'(cand_x_pos), mcx);
        check("cand_y", int'(cand_y_pos), mcy);
      end
    end
  end

  // Buttons are {up, down, left, right}; they stay held after the tick.
  task automatic tick(input logic [3:0] b);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = b;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ack(input logic blocked);
    check_ack = 1'b1;
    check_blocked = blocked;
    @(negedge clk);
    check_ack = 1'b0;
    check_blocked = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt, moves;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_x", int'(hero_x_pos), 62);
    check("rst_y", int'(hero_y_pos), 108);
    check("rst_dir", int'(hero_dir), 1);
    check("rst_req", int'(check_req), 0);

    // Right move, clear ack: commit lands two edges after ack.
    tick(4'b0001);
    check("s1_req", int'(check_req), 1);
    check("s1_cand_x", int'(cand_x_pos), 66);
    ack(1'b0);
    check("s1_x_not_yet", int'(hero_x_pos), 62);
    @(negedge clk);
    check("s1_x", int'(hero_x_pos), 66);
    check("s1_moving", int'(moving), 1);

    // Left at the left edge: refused without a request, but the hero turns.
    do_reset();
    tick(4'b0010);
    check("s2_req", int'(check_req), 0);
    check("s2_bump", int'(bump), 1);
    check("s2_dir", int'(hero_dir), 2);
    check("s2_x", int'(hero_x_pos), 62);

    // Step down once, then up+right (up wins) refused by the checker.
    tick(4'b0100);
    ack(1'b0);
    @(negedge clk);
    check("s3_y_down", int'(hero_y_pos), 112);
    tick(4'b1001);
    check("s3_cand_y", int'(cand_y_pos), 108);
    ack(1'b1);
    check("s3_bump", int'(bump), 1);
    check("s3_dir", int'(hero_dir), 0);
    @(negedge clk);
    check("s3_y", int'(hero_y_pos), 112);

    // No ack: the request stays up for exactly ACK_TIMEOUT cycles.
    tick(4'b0001);
    cnt = 0;
    while (check_req && cnt < 1100) begin
      cnt++;
      @(negedge clk);
    end
    check("s4_req_cycles", cnt, 1023);
    check("s4_bump", int'(bump), 1);
    check("s4_x", int'(hero_x_pos), 62);

    // Reset mid-handshake, then a late ack.
    do_reset();
    tick(4'b0001);
    check("s5_req_before", int'(check_req), 1);
    rst = 1'b1;
    @(negedge clk);
    check("s5_req_on_rst", int'(check_req), 0);
    rst = 1'b0;
    ack(1'b0);
    repeat (3) @(negedge clk);
    check("s5_x", int'(hero_x_pos), 62);
    check("s5_y", int'(hero_y_pos), 108);

    // Extra ticks during WAIT_ACK and COMMIT are ignored.
    tick(4'b0001);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check_ack = 1'b1;
    @(negedge clk);
    check_ack = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    check("s6_x", int'(hero_x_pos), 66);
    check("s6_req", int'(check_req), 0);

    // A tick with no buttons ends the moving frame.
    tick(4'b0000);
    check("s7_moving", int'(moving), 0);

    // March right to the edge; the move past X_MAX is refused.
    moves = 0;
    for (int i = 0; i < 260; i++) begin
      tick(4'b0001);
      if (bump) break;
      if (check_req) begin
        ack(1'b0);
        moves++;
      end
      @(negedge clk);
    end
    check("s8_moves", moves, 209);
    check("s8_x", int'(hero_x_pos), 902);
    check("s8_dir", int'(hero_dir), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
